rx_capture_ctrl: RTL and testbench
==================================

Name: rx_capture_ctrl

Overview:
- Capture controller that sits directly upstream of the rx 1024 x 18 simple dual-port sample BRAM.
- While capturing, it writes incoming rx samples into the BRAM as a circular buffer.
- On a trigger, it keeps PRE_TRIG samples from before the trigger and fills the rest with post-trigger samples.
- It then reads the whole window back through the BRAM read port as an ordered stream for the downstream correlator.

Parameters:
ADDR_W, 10, BRAM address width; DEPTH = 2**ADDR_W
DATA_W, 18, sample width
PRE_TRIG, 256, samples retained before the trigger sample; legal range 1..DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  arm pulse; honoured only in IDLE
sample_valid  in  1  sample_data valid this cycle
sample_data  in  DATA_W  rx sample
trigger  in  1  capture trigger; honoured only in ARMED
bram_ena  out  1  BRAM write-port enable
bram_wea  out  1  BRAM write enable
bram_addra  out  ADDR_W  BRAM write address
bram_dia  out  DATA_W  BRAM write data
bram_enb  out  1  BRAM read enable
bram_addrb  out  ADDR_W  BRAM read address
bram_dob  in  DATA_W  BRAM read data, valid 1 cycle after bram_enb
out_valid  out  1  readout word valid
out_data  out  DATA_W  readout word
out_last  out  1  high with final readout word
busy  out  1  high in every state except IDLE

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, all pointers and counters 0. BRAM contents are not cleared.
- Reset mid-operation behaves identically: the capture is aborted and the next start behaves as after power-up.
- All BRAM port outputs are registered.
- A sample accepted at cycle t appears as bram_ena=bram_wea=1, bram_addra=wr_ptr, bram_dia=sample at t+1.
- IDLE: no BRAM activity; sample_valid and trigger are ignored.
  - start -> FILL; wr_ptr=0, fill_cnt=0.
- FILL: each sample_valid writes at wr_ptr, then wr_ptr++ modulo DEPTH and fill_cnt++.
  - When fill_cnt reaches PRE_TRIG -> ARMED.
  - trigger is ignored in FILL.
- ARMED: writes continue circularly, overwriting the oldest data.
  - On trigger: trig_addr = wr_ptr; post_cnt = DEPTH-PRE_TRIG; state -> POST.
  - If sample_valid is high in the trigger cycle, that sample is the trigger sample and counts as the first post sample.
- POST: each sample_valid writes and decrements post_cnt.
  - When post_cnt reaches 0 -> READ, with rd_ptr = wr_ptr (equal to trig_addr-PRE_TRIG mod DEPTH, the oldest retained sample).
  - Further trigger pulses are ignored.
- READ: sample_valid is ignored (bram_ena=0).
  - bram_enb=1 for exactly DEPTH consecutive cycles, bram_addrb = rd_ptr, incrementing with wrap.
  - out_valid/out_data follow bram_dob one cycle after each read.
  - out_last is asserted with word DEPTH.
  - After the last word, state -> IDLE, busy=0.
- Readout has no backpressure: the consumer must accept one word per cycle.
- start outside IDLE is ignored.
- No combinational path from inputs to outputs.

Optional Feature:
Macro RX_CAPTURE_TIMESTAMP_EN.
- Defined:
  - Adds output trig_ts [31:0], reset 0.
  - A 32-bit free-running counter increments on every accepted sample_valid, from reset; it wraps at 2^32.
  - trig_ts latches the counter value of the trigger sample on entry to POST and holds until the next trigger.
- Undefined: no counter and no trig_ts port; behaviour is otherwise identical.

Test Plan:
1. start; feed sample_data = index 0,1,2,… every cycle; pulse trigger with sample 300 -> 1024 out_valid words 44..1067 on consecutive cycles; out_last with 1067 (written at addr 43); busy drops after it.
2. trigger pulsed with sample 100 (in FILL) is ignored; trigger with sample 256 (first ARMED sample) -> readout 0..1023, first read at bram_addrb=0.
3. sample_valid one cycle in three, trigger with sample 300 -> same readout as case 1; bram_wea pulses only one cycle after valid samples.
4. rst_n low during POST -> all outputs 0 immediately (async); after release, start plus case 1 stimulus gives the case 1 result.
5. start and sample_valid held high during READ -> bram_ena stays 0, readout uninterrupted, state returns to IDLE; a start afterwards enters FILL.
6. With RX_CAPTURE_TIMESTAMP_EN: 5000 samples accepted before start, trigger with the 300th sample after start -> trig_ts = 5300.

Source files
------------

// File: rtl/rx_capture_ctrl.sv
// Pre/post-trigger capture controller in front of the rx sample BRAM. It writes samples into a circular buffer and replays the trigger window in order.
// The optional trig_ts timestamp output is enabled by defining RX_CAPTURE_TIMESTAMP_EN.
module rx_capture_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 18,
  parameter int PRE_TRIG = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trigger,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dia,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef RX_CAPTURE_TIMESTAMP_EN
  ,
  output logic [31:0]       trig_ts
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] PRE_CNT  = (ADDR_W + 1)'(PRE_TRIG);
  localparam logic [ADDR_W:0] POST_CNT = (ADDR_W + 1)'(DEPTH - PRE_TRIG);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     fill_cnt_q, post_cnt_q;
  logic [ADDR_W-1:0]   rd_cnt_q;
  logic                ena_q, wea_q, enb_q;
  logic [ADDR_W-1:0]   addra_q, addrb_q;
  logic [DATA_W-1:0]   dia_q, out_data_q;
  logic                dvld_q, dlast_q, out_valid_q, out_last_q;
  logic                enb_last;
`ifdef RX_CAPTURE_TIMESTAMP_EN
  logic [31:0]         ts_cnt_q, trig_ts_q;
`endif

  assign wr_ptr_d = wr_ptr_q + 1'b1;
  // The read issued this cycle is the final word of the window.
  assign enb_last = enb_q && (rd_cnt_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dia_q       <= '0;
      enb_q       <= 1'b0;
      addrb_q     <= '0;
      dvld_q      <= 1'b0;
      dlast_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef RX_CAPTURE_TIMESTAMP_EN
      ts_cnt_q    <= '0;
      trig_ts_q   <= '0;
`endif
    end else begin
      ena_q       <= 1'b0;
      wea_q       <= 1'b0;
      dvld_q      <= enb_q;
      dlast_q     <= enb_last;
      out_valid_q <= dvld_q;
      out_last_q  <= dlast_q;
      if (dvld_q) out_data_q <= bram_dob;
`ifdef RX_CAPTURE_TIMESTAMP_EN
      if (sample_valid) ts_cnt_q <= ts_cnt_q + 1'b1;
`endif
      // Every capturing state writes accepted samples the same way.
      if (sample_valid && (state_q == FILL || state_q == ARMED || state_q == POST)) begin
        ena_q    <= 1'b1;
        wea_q    <= 1'b1;
        addra_q  <= wr_ptr_q;
        dia_q    <= sample_data;
        wr_ptr_q <= wr_ptr_d;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
          end
        end
        FILL: begin
          if (sample_valid) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            if ((fill_cnt_q + 1'b1) == PRE_CNT) state_q <= ARMED;
          end
        end
        ARMED: begin
          if (trigger) begin
`ifdef RX_CAPTURE_TIMESTAMP_EN
            trig_ts_q <= ts_cnt_q;
`endif
            if (sample_valid) begin
              post_cnt_q <= POST_CNT - 1'b1;
              if (POST_CNT == (ADDR_W + 1)'(1)) begin
                state_q  <= READ;
                enb_q    <= 1'b1;
                addrb_q  <= wr_ptr_d;
                rd_cnt_q <= '0;
              end else begin
                state_q <= POST;
              end
            end else begin
              post_cnt_q <= POST_CNT;
              state_q    <= POST;
            end
          end
        end
        POST: begin
          if (sample_valid) begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == (ADDR_W + 1)'(1)) begin
              state_q  <= READ;
              enb_q    <= 1'b1;
              addrb_q  <= wr_ptr_d;
              rd_cnt_q <= '0;
            end
          end
        end
        READ: begin
          if (enb_q) begin
            if (enb_last) begin
              enb_q <= 1'b0;
            end else begin
              addrb_q  <= addrb_q + 1'b1;
              rd_cnt_q <= rd_cnt_q + 1'b1;
            end
          end
          if (out_last_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bram_ena   = ena_q;
  assign bram_wea   = wea_q;
  assign bram_addra = addra_q;
  assign bram_dia   = dia_q;
  assign bram_enb   = enb_q;
  assign bram_addrb = addrb_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign busy       = (state_q != IDLE);
`ifdef RX_CAPTURE_TIMESTAMP_EN
  assign trig_ts    = trig_ts_q;
`endif

endmodule

// File: tb/tb_rx_capture_ctrl.sv
// Directed bench for rx_capture_ctrl with a behavioural 1024x18 BRAM; checks capture, trigger window readout, reset abort and start/valid during readout.
module tb_rx_capture_ctrl;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 18;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              trigger = 1'b0;
  logic              bram_ena, bram_wea, bram_enb;
  logic [ADDR_W-1:0] bram_addra, bram_addrb;
  logic [DATA_W-1:0] bram_dia, out_data;
  logic [DATA_W-1:0] bram_dob = '0;
  logic              out_valid, out_last, busy;
`ifdef RX_CAPTURE_TIMESTAMP_EN
  logic [31:0]       trig_ts;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem[bram_addra] <= bram_dia;
    if (bram_enb) bram_dob <= mem[bram_addrb];
  end

  rx_capture_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_valid(sample_valid),
    .sample_data(sample_data), .trigger(trigger),
    .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dia(bram_dia),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_dob(bram_dob),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy)
`ifdef RX_CAPTURE_TIMESTAMP_EN
    , .trig_ts(trig_ts)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a capture, feed samples 0,1,2,... (valid every 'period' cycles), trigger with
  // sample trig_idx, then collect the readout and compare against exp_base, exp_base+1, ...
  task automatic run_case(input string name, input int trig_idx, input int period,
                          input bit early_trig, input bit hold_in_read,
                          input int exp_base, input int exp_addrb0);
    int idx = 0, cyc = 0, nw = 0, first_cyc = -1, last_cyc = -1;
    int wea_err = 0, ena_err = 0, data_err = 0, last_err = 0;
    int first_addrb = -1;
    bit busy_at_last = 1'b0;
    bit v;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    while (idx < trig_idx + (DEPTH - 256)) begin
      v = (cyc % period) == 0;
      sample_valid = v;
      sample_data  = DATA_W'(idx);
      trigger      = v && (idx == trig_idx || (early_trig && idx == 100));
      tick();
      if (bram_wea !== v || bram_ena !== v) wea_err++;
      if (v && (32'(bram_addra) !== 32'(idx % DEPTH) || 32'(bram_dia) !== 32'(idx))) wea_err++;
      if (bram_enb && first_addrb < 0) first_addrb = int'(bram_addrb);
      if (v) idx++;
      cyc++;
    end
    trigger      = 1'b0;
    sample_valid = hold_in_read;
    start        = hold_in_read;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (bram_ena || bram_wea) ena_err++;
      if (bram_enb && first_addrb < 0) first_addrb = int'(bram_addrb);
      if (out_valid) begin
        if (32'(out_data) !== 32'(exp_base + nw)) data_err++;
        if (out_last !== (nw == DEPTH - 1)) last_err++;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nw++;
      end else if (out_last) begin
        last_err++;
      end
      if (out_last) begin
        busy_at_last = busy;
        break;
      end
    end
    chk({name, "_words"}, 32'(nw), 32'(DEPTH));
    chk({name, "_data_errs"}, 32'(data_err), 32'd0);
    chk({name, "_last_errs"}, 32'(last_err), 32'd0);
    chk({name, "_span"}, 32'(last_cyc - first_cyc + 1), 32'(DEPTH));
    chk({name, "_first_addrb"}, 32'(first_addrb), 32'(exp_addrb0));
    chk({name, "_write_errs"}, 32'(wea_err), 32'd0);
    chk({name, "_ena_in_read"}, 32'(ena_err), 32'd0);
    chk({name, "_busy_at_last"}, 32'(busy_at_last), 32'd1);
    tick();
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    start        = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_outs", {bram_ena, bram_wea, bram_enb, out_valid, out_last,
                       12'(bram_addra), 15'(out_data)}, 32'd0);
    tick();
    rst_n = 1'b1;

    // IDLE ignores samples and triggers
    sample_valid = 1'b1;
    trigger      = 1'b1;
    sample_data  = 18'h3ABCD;
    tick();
    tick();
    chk("idle_no_write", 32'({bram_ena, bram_wea}), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    sample_valid = 1'b0;
    trigger      = 1'b0;

    run_case("c1", 300, 1, 1'b0, 1'b0, 44, 44);
    run_case("c2", 256, 1, 1'b1, 1'b0, 0, 0);
    run_case("c3", 300, 3, 1'b0, 1'b0, 44, 44);

    // Reset during POST aborts the capture
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 500; i++) begin
      sample_valid = 1'b1;
      sample_data  = DATA_W'(i);
      trigger      = (i == 300);
      tick();
    end
    chk("pre_rst_addra", 32'(bram_addra), 32'd500);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_port", {bram_ena, bram_wea, 12'(bram_addra), 18'(bram_dia)}, 32'd0);
    chk("rst_rd_port", {bram_enb, out_valid, out_last, 11'(bram_addrb), 18'(out_data)}, 32'd0);
    sample_valid = 1'b0;
    trigger      = 1'b0;
    tick();
    rst_n = 1'b1;
    run_case("c4", 300, 1, 1'b0, 1'b0, 44, 44);

    // start and sample_valid held high through readout
    run_case("c5", 300, 1, 1'b0, 1'b1, 44, 44);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("c5_restart_busy", 32'(busy), 32'd1);
    sample_valid = 1'b1;
    sample_data  = 18'd77;
    tick();
    sample_valid = 1'b0;
    chk("c5_restart_write", {bram_ena, bram_wea, 12'(bram_addra), 18'(bram_dia)},
        {1'b1, 1'b1, 12'd0, 18'd77});

`ifdef RX_CAPTURE_TIMESTAMP_EN
    rst_n = 1'b0;
    #1;
    chk("ts_reset", trig_ts, 32'd0);
    tick();
    rst_n = 1'b1;
    sample_valid = 1'b1;
    for (int i = 0; i < 5000; i++) tick();
    sample_valid = 1'b0;
    run_case("c6", 300, 1, 1'b0, 1'b0, 44, 44);
    chk("c6_trig_ts", trig_ts, 32'd5300);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
